// File: rtl/psa_pkg.sv
// Shared types and the partitioned nibble adder for psa_sched.
// Optional feature macro: PSA_SAT_EN (saturate overflowed nibbles instead of wrapping).
package psa_pkg;

    localparam int NIBBLES = 4;
    localparam int NIB_W   = 4;

    typedef logic [15:0] psa_word_t;
    typedef logic [3:0]  psa_ovf_t;

    localparam logic [3:0] SAT_POS = 4'h7;
    localparam logic [3:0] SAT_NEG = 4'h8;

    // Returns {ovf, sum}; each nibble is an independent signed lane with no carry between lanes.
    function automatic logic [19:0] psa_add(input psa_word_t a, input psa_word_t b);
        psa_word_t  sum;
        psa_ovf_t   ovf;
        logic [3:0] s;
        sum = 16'h0000;
        ovf = 4'h0;
        for (int k = 0; k < NIBBLES; k++) begin
            s      = a[NIB_W*k +: NIB_W] + b[NIB_W*k +: NIB_W];
            ovf[k] = (a[NIB_W*k+3] == b[NIB_W*k+3]) && (s[3] != a[NIB_W*k+3]);
`ifdef PSA_SAT_EN
            // Both operands share a sign on overflow, so that sign picks the clamp value.
            sum[NIB_W*k +: NIB_W] = ovf[k] ? (a[NIB_W*k+3] ? SAT_NEG : SAT_POS) : s;
`else
            sum[NIB_W*k +: NIB_W] = s;
`endif
        end
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/psa_rr_arb.sv
// Round-robin arbiter: grants the first set request at or after ptr_i, searching circularly.
module psa_rr_arb
    import psa_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o
);

    // Circular priority search starting at the pointer.
    always_comb begin
        logic            found;
        logic            hit;
        logic [ID_W-1:0] idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        hit       = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx        = ID_W'((int'(ptr_i) + i) % NUM_REQ);
            hit        = en_i && !found && req_i[idx];
            gnt_o[idx] = gnt_o[idx] | hit;
            gnt_idx_o  = hit ? idx : gnt_idx_o;
            found      = found | hit;
        end
    end

endmodule

// File: rtl/psa_sched.sv
// Shares one partitioned nibble adder among NUM_REQ requesters with a one-slot registered output.
// Optional feature macro: PSA_SAT_EN (see psa_pkg::psa_add).
module psa_sched
    import psa_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*16-1:0] req_a_i,
    input  logic [NUM_REQ*16-1:0] req_b_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [15:0]           resp_sum_o,
    output logic [3:0]            resp_ovf_o,
    output logic [ID_W-1:0]       resp_id_o
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e     state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    psa_word_t       sum_q, sum_d;
    psa_ovf_t        ovf_q, ovf_d;
    logic [ID_W-1:0] id_q, id_d;

    logic               accept_ok_s;
    logic               accept_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [ID_W-1:0]    gnt_idx_s;
    psa_word_t          a_sel_s;
    psa_word_t          b_sel_s;
    logic [19:0]        add_res_s;

    // Held low during reset so no requester believes it was accepted.
    assign accept_ok_s = !rst && ((state_q == SLOT_EMPTY) || resp_ready_i);

    psa_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .en_i      (accept_ok_s),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s)
    );

    assign req_ready_o = gnt_s;
    assign accept_s    = |gnt_s;

    // One-hot AND-OR operand mux driven by the grant vector.
    always_comb begin
        a_sel_s = 16'h0000;
        b_sel_s = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_sel_s = a_sel_s | (gnt_s[i] ? req_a_i[16*i +: 16] : 16'h0000);
            b_sel_s = b_sel_s | (gnt_s[i] ? req_b_i[16*i +: 16] : 16'h0000);
        end
    end

    assign add_res_s = psa_add(a_sel_s, b_sel_s);

    // Slot FSM next state, result capture and round-robin pointer update.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sum_d    = sum_q;
        ovf_d    = ovf_q;
        id_d     = id_q;
        if (accept_s) begin
            state_d  = SLOT_FULL;
            sum_d    = add_res_s[15:0];
            ovf_d    = add_res_s[19:16];
            id_d     = gnt_idx_s;
            rr_ptr_d = (gnt_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + ID_W'(1);
        end else begin
            case (state_q)
                SLOT_EMPTY: state_d = SLOT_EMPTY;
                SLOT_FULL:  state_d = resp_ready_i ? SLOT_EMPTY : SLOT_FULL;
                default:    state_d = SLOT_EMPTY;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SLOT_EMPTY;
            rr_ptr_q <= '0;
            sum_q    <= 16'h0000;
            ovf_q    <= 4'h0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sum_q    <= sum_d;
            ovf_q    <= ovf_d;
            id_q     <= id_d;
        end
    end

    assign resp_valid_o = (state_q == SLOT_FULL);
    assign resp_sum_o   = sum_q;
    assign resp_ovf_o   = ovf_q;
    assign resp_id_o    = id_q;

endmodule

// File: tb/tb_psa_sched.sv
// Directed self-checking bench for psa_sched (expectations follow PSA_SAT_EN when defined).
module tb_psa_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [15:0]           resp_sum;
    logic [3:0]            resp_ovf;
    logic [ID_W-1:0]       resp_id;

    int n_tests = 0;
    int n_fail  = 0;

    psa_sched #(.NUM_REQ(NUM_REQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_sum_o   (resp_sum),
        .resp_ovf_o   (resp_ovf),
        .resp_id_o    (resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-requester transaction: grant now, result registered on the next cycle.
    task automatic issue(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_sum, input logic [3:0] exp_ovf, input string tag);
        req_a[16*idx +: 16] = a;
        req_b[16*idx +: 16] = b;
        req_valid           = 4'b0001 << idx;
        #1;
        check_eq({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << idx));
        tick();
        req_valid = 4'b0000;
        check_eq({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check_eq({tag, "_sum"}, 32'(resp_sum), 32'(exp_sum));
        check_eq({tag, "_ovf"}, 32'(resp_ovf), 32'(exp_ovf));
        check_eq({tag, "_id"}, 32'(resp_id), 32'(idx));
    endtask

    initial begin
        logic [15:0] held_sum;
        int          g;
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        #2;
        req_valid = 4'b1111;
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_sum", 32'(resp_sum), 32'd0);
        check_eq("rst_ovf", 32'(resp_ovf), 32'd0);
        check_eq("rst_id", 32'(resp_id), 32'd0);
        req_valid = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic add, overflow both directions, no carry across nibbles (ptr ends at 0).
        issue(0, 16'h1234, 16'h1111, 16'h2345, 4'h0, "t1");
`ifdef PSA_SAT_EN
        issue(1, 16'h7777, 16'h1111, 16'h7777, 4'hF, "t2_pos");
        issue(2, 16'h8888, 16'hFFFF, 16'h8888, 4'hF, "t3_neg");
`else
        issue(1, 16'h7777, 16'h1111, 16'h8888, 4'hF, "t2_pos");
        issue(2, 16'h8888, 16'hFFFF, 16'h7777, 4'hF, "t3_neg");
`endif
        issue(3, 16'hF0F0, 16'h0F0F, 16'hFFFF, 4'h0, "t3_nocarry");

        // All requesters valid: grants 0,1,2,3 then 0 again (req0 re-raised).
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[16*i +: 16] = 16'(i);
            req_b[16*i +: 16] = 16'h0010;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            g = c % NUM_REQ;
            #1;
            check_eq("t4_gnt", 32'(req_ready), 32'(4'b0001 << g));
            tick();
            check_eq("t4_id", 32'(resp_id), 32'(g));
            check_eq("t4_sum", 32'(resp_sum), 32'(16'h0010 + 16'(g)));
            req_valid[g] = 1'b0;
            if (c == 3) req_valid[0] = 1'b1;
        end
        // ptr now 1: mixed-lane overflow on requester 1.
`ifdef PSA_SAT_EN
        issue(1, 16'h3C5A, 16'h2468, 16'h5078, 4'h3, "t_mixed");
`else
        issue(1, 16'h3C5A, 16'h2468, 16'h50B2, 4'h3, "t_mixed");
`endif

        // Backpressure: slot holds, no grant, ptr (2) unchanged.
        resp_ready          = 1'b0;
        req_a[16*0 +: 16]   = 16'h1000;
        req_b[16*0 +: 16]   = 16'h0001;
        req_a[16*2 +: 16]   = 16'h2000;
        req_b[16*2 +: 16]   = 16'h0002;
        req_valid           = 4'b0101;
        held_sum            = resp_sum;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("t5_ready_hold", 32'(req_ready), 32'd0);
            tick();
            check_eq("t5_valid_hold", 32'(resp_valid), 32'd1);
            check_eq("t5_sum_hold", 32'(resp_sum), 32'(held_sum));
            check_eq("t5_id_hold", 32'(resp_id), 32'd1);
        end
        resp_ready = 1'b1;
        #1;
        check_eq("t5_b2b_gnt", 32'(req_ready), 32'b0100);
        tick();
        check_eq("t5_b2b_valid", 32'(resp_valid), 32'd1);
        check_eq("t5_b2b_id", 32'(resp_id), 32'd2);
        check_eq("t5_b2b_sum", 32'(resp_sum), 32'h2002);
        req_valid  = 4'b0000;
        resp_ready = 1'b0;
        tick();

        // Async reset mid-cycle with a pending result; ptr was 3 beforehand.
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_async_valid", 32'(resp_valid), 32'd0);
        check_eq("t6_async_sum", 32'(resp_sum), 32'd0);
        tick();
        rst        = 1'b0;
        resp_ready = 1'b1;
        req_a[16*3 +: 16] = 16'h3000;
        req_b[16*3 +: 16] = 16'h0003;
        req_valid  = 4'b1001;
        #1;
        check_eq("t6_first_gnt", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        check_eq("t6_id", 32'(resp_id), 32'd0);
        check_eq("t6_sum", 32'(resp_sum), 32'h1001);
        tick();
        check_eq("t6_drain", 32'(resp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
